// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter with a prescaler that paces count steps.
// Outputs are registered; carry and step are single-cycle pulses.
module bcd_updown_counter #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic       step
);

    localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);

    logic [15:0] presc;
    logic        step_cond;
    logic [3:0]  ones_nx;
    logic [3:0]  tens_nx;
    logic        wrap;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
        return (nib > 4'd9) ? 4'd9 : nib;
    endfunction

    assign step_cond = en && (presc == PRESC_LAST);

    always_comb begin
        ones_nx = ones;
        tens_nx = tens;
        wrap    = 1'b0;
        if (up) begin
            if (ones == 4'd9) begin
                ones_nx = 4'd0;
                if (tens == 4'd9) begin
                    tens_nx = 4'd0;
                    wrap    = 1'b1;
                end else begin
                    tens_nx = tens + 4'd1;
                end
            end else begin
                ones_nx = ones + 4'd1;
            end
        end else begin
            if (ones == 4'd0) begin
                ones_nx = 4'd9;
                if (tens == 4'd0) begin
                    tens_nx = 4'd9;
                    wrap    = 1'b1;
                end else begin
                    tens_nx = tens - 4'd1;
                end
            end else begin
                ones_nx = ones - 4'd1;
            end
        end
    end

    // clr and load both restart the prescaler phase and suppress any pending step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            ones  <= '0;
            tens  <= '0;
            carry <= 1'b0;
            step  <= 1'b0;
        end else if (clr) begin
            presc <= '0;
            ones  <= '0;
            tens  <= '0;
            carry <= 1'b0;
            step  <= 1'b0;
        end else if (load) begin
            presc <= '0;
            ones  <= clamp_bcd(load_val[3:0]);
            tens  <= clamp_bcd(load_val[7:4]);
            carry <= 1'b0;
            step  <= 1'b0;
        end else begin
            carry <= 1'b0;
            step  <= 1'b0;
            if (en) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 16'd1;
                if (step_cond) begin
                    ones  <= ones_nx;
                    tens  <= tens_nx;
                    carry <= wrap;
                    step  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIV, default 4, is the number of enabled clock cycles per count step; legal range is 1..65535.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  is the asynchronous, active-high reset.
REQ-004 en  input  1  is the count enable; the prescaler advances only while en=1.
REQ-005 up  input  1  selects direction: 1 counts up, 0 counts down; it is sampled on the step cycle.
REQ-006 clr  input  1  is the synchronous clear of the digits and the prescaler.
REQ-007 load  input  1  is the synchronous load strobe.
REQ-008 load_val  input  8  is the load value: [7:4] is the tens BCD digit and [3:0] is the ones BCD digit.
REQ-009 ones  output  4  is the ones BCD digit, 0..9, which feeds a 7-segment decoder directly.
REQ-010 tens  output  4  is the tens BCD digit, 0..9, which feeds a 7-segment decoder directly.
REQ-011 carry  output  1  is a one-cycle pulse on wrap-around in either direction.
REQ-012 step  output  1  is a one-cycle pulse marking each cycle on which the count changes due to counting.

Function
REQ-013 Synchronous priority per rising edge SHALL be clr > load > count step > hold.
REQ-014 The prescaler SHALL be a counter running 0..DIV-1; when en=1 it increments, and at DIV-1 it wraps to 0.
REQ-015 When en=0, the prescaler and the digits SHALL hold their values.
REQ-016 A step SHALL occur on a cycle where en=1 and the prescaler equals DIV-1, and on no other cycle; with DIV=1, every enabled cycle is a step.
REQ-017 step, carry, ones and tens SHALL be registered: they update on the same edge that consumes the step condition, so step reads high for exactly the cycle following that edge.
REQ-018 An up step SHALL change ones as 0->1->...->9->0; on 9->0, tens increments.
REQ-019 On an up step, 99 SHALL go to 00 with carry=1.
REQ-020 A down step SHALL change ones as 9->8->...->0->9; on 0->9, tens decrements.
REQ-021 On a down step, 00 SHALL go to 99 with carry=1.
REQ-022 carry and step SHALL be 0 on every cycle not produced by a step, including the cycles after clr and load.
REQ-023 clr=1 SHALL set ones=0, tens=0 and prescaler=0, with step=0 and carry=0, regardless of en, load or the step condition.
REQ-024 load=1 with clr=0 SHALL copy load_val into tens and ones and set prescaler=0, with step=0 and carry=0; any pending step on that cycle is discarded.
REQ-025 Any load nibble of 10..15 SHALL be stored as 9, and each nibble is clamped independently (e.g. 8'hA3 -> 93, 8'h5F -> 59).
REQ-026 A change of up between steps SHALL affect only the next step, and the prescaler phase is unaffected.
REQ-027 ones and tens SHALL never hold a value above 9 on any cycle.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for clk, force ones=0, tens=0, prescaler=0, step=0 and carry=0.
REQ-029 Asserting reset mid-count SHALL abandon the prescaler phase; after release, the first step occurs DIV enabled cycles later.
REQ-030 clr and load SHALL be ignored while reset=1.

Verification (DIV=4 unless stated)
REQ-031 Scenario: release reset, hold en=1 and up=1 -> step pulses every 4 cycles and ones reaches 1 after 4 edges; after 40 steps the count is 40 with no carry.
REQ-032 Scenario: load 8'h98, then 2 up steps -> the count goes 99 then 00, with carry=1 exactly on the 99->00 update and 0 otherwise.
REQ-033 Scenario: load 8'h00 with up=0, then 1 step -> the count is 99 and carry=1 for one cycle; the next step gives 98 with carry=0.
REQ-034 Scenario: load 8'hFC -> the count is 99 (both nibbles clamped); then assert clr and load together -> the count is 00.
REQ-035 Scenario: en toggles 1,0,1,1,1 from prescaler=0 -> the first step fires on the 4th enabled cycle, and the count holds during en=0.
REQ-036 Scenario: DIV=1, assert reset asynchronously mid-cycle while the count is 57 -> the outputs read 00 before the next clk edge; after release, a step occurs on every enabled cycle.
